// File: rtl/seq_and_or_stim_chk.sv
`default_nettype none
// ============================================================================
// Module   : seq_and_or_stim_chk
// Purpose  : LFSR stimulus driver and cycle-accurate response checker for the
//            seq_inst_and_or pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module seq_and_or_stim_chk #(
  parameter int          NUM_VEC = 256,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             n_in,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             e,
  output logic             f,
  output logic             g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [15:0] C_SEED  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] C_TAPS  = 16'hB400;
  localparam int          C_IDX_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(NUM_VEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [15:0]        r_lfsr;
  logic [6:0]         r_vec;
  logic [C_IDX_W-1:0] r_idx;
  logic [1:0]         r_drain;
  logic               r_jm;
  logic               r_km;
  logic               r_nm;
  logic [1:0]         r_vld;
  logic [CNT_W-1:0]   r_vec_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  logic               w_launch;
  logic               w_last;
  logic               w_miss;

  function automatic logic cao(input logic w, input logic x, input logic y, input logic z);
    return (w & x) | (y & z);
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? C_TAPS : 16'h0000);
  endfunction

  assign w_last = (r_idx == C_LAST_IDX);
  // r_vld[1] marks the cycle carrying the response of a vector driven two cycles ago
  assign w_miss = r_vld[1] & (n_in ^ r_nm);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    pass        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (r_drain == 2'd2) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        pass = (r_err_cnt == '0);
        if (start) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr    <= C_SEED;
      r_vec     <= 7'h00;
      r_idx     <= '0;
      r_drain   <= 2'd0;
      r_jm      <= 1'b0;
      r_km      <= 1'b0;
      r_nm      <= 1'b0;
      r_vld     <= 2'b00;
      r_vec_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      // Reference copy of the pipeline, fed from the same registered a..g
      r_jm  <= cao(r_vec[6], r_vec[5], r_vec[4], r_vec[3]);
      r_km  <= r_vec[4] & r_vec[3];
      r_nm  <= r_jm ^ cao(r_km, r_vec[2], r_vec[1], r_vec[0]);
      r_vld <= {r_vld[0], (r_state == ST_RUN)};

      r_drain <= (r_state == ST_DRAIN) ? r_drain + 2'd1 : 2'd0;

      if (w_miss && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end

      // The seed vector is presented in the first RUN cycle, so the LFSR leads by one step
      if (w_launch) begin
        r_vec     <= C_SEED[6:0];
        r_lfsr    <= lfsr_step(C_SEED);
        r_idx     <= '0;
        r_vec_cnt <= '0;
        r_err_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        r_vec     <= w_last ? 7'h00 : r_lfsr[6:0];
        r_lfsr    <= lfsr_step(r_lfsr);
        r_idx     <= r_idx + C_IDX_W'(1);
        r_vec_cnt <= r_vec_cnt + CNT_W'(1);
      end else begin
        r_vec <= 7'h00;
      end
    end
  end

  assign {a, b, c, d, e, f, g} = r_vec;
  assign vec_cnt = r_vec_cnt;
  assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_and_or_stim_chk.sv
`default_nettype none
// Testbench for seq_and_or_stim_chk: emulated pipeline DUT on n_in, LFSR and
// fault-count reference model with randomized fault injection.
module tb_seq_and_or_stim_chk;

  localparam logic [15:0] C_SEED = 16'hACE1;
  localparam int          C_N8   = 8;

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic start8  = 1'b0;
  logic start20 = 1'b0;
  logic inv8    = 1'b0;
  logic flip8   = 1'b0;
  logic inv20   = 1'b0;

  logic        n_in8, a8, b8, c8, d8, e8, f8, g8, busy8, done8, pass8;
  logic [15:0] vec_cnt8, err_cnt8;
  logic        n_in20, a20, b20, c20, d20, e20, f20, g20, busy20, done20, pass20;
  logic [3:0]  vec_cnt20, err_cnt20;

  logic j8, k8, n8, j20, k20, n20;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_vec [0:C_N8-1];
  logic [6:0] seen8   [0:31];

  always #5 clk = ~clk;

  seq_and_or_stim_chk #(.NUM_VEC(8), .SEED(C_SEED), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .n_in(n_in8),
    .a(a8), .b(b8), .c(c8), .d(d8), .e(e8), .f(f8), .g(g8),
    .busy(busy8), .done(done8), .pass(pass8),
    .vec_cnt(vec_cnt8), .err_cnt(err_cnt8)
  );

  seq_and_or_stim_chk #(.NUM_VEC(20), .SEED(C_SEED), .CNT_W(4)) dut20 (
    .clk(clk), .rst(rst), .start(start20), .n_in(n_in20),
    .a(a20), .b(b20), .c(c20), .d(d20), .e(e20), .f(f20), .g(g20),
    .busy(busy20), .done(done20), .pass(pass20),
    .vec_cnt(vec_cnt20), .err_cnt(err_cnt20)
  );

  // Stand-ins for the seq_inst_and_or pipeline being checked
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      j8 <= 1'b0; k8 <= 1'b0; n8 <= 1'b0;
      j20 <= 1'b0; k20 <= 1'b0; n20 <= 1'b0;
    end else begin
      j8  <= (a8 & b8) | (c8 & d8);
      k8  <= c8 & d8;
      n8  <= j8 ^ ((k8 & e8) | (f8 & g8));
      j20 <= (a20 & b20) | (c20 & d20);
      k20 <= c20 & d20;
      n20 <= j20 ^ ((k20 & e20) | (f20 & g20));
    end
  end

  assign n_in8  = n8 ^ inv8 ^ flip8;
  assign n_in20 = n20 ^ inv20;

  function automatic logic [15:0] next_lfsr(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic build_expect;
    logic [15:0] s;
    s = C_SEED;
    for (int i = 0; i < C_N8; i++) begin
      exp_vec[i] = s[6:0];
      s = next_lfsr(s);
    end
  endtask

  // Launch one 8-vector run; mask bit c inverts n_in during cycle c after launch
  task automatic run8(input logic [31:0] mask, input logic inv, output int cycles);
    inv8 = inv;
    @(negedge clk); start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    cycles = 0;
    while (busy8 && cycles < 64) begin
      if (cycles < 32) begin
        seen8[cycles] = {a8, b8, c8, d8, e8, f8, g8};
        flip8 = mask[cycles];
      end else begin
        flip8 = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    flip8 = 1'b0;
    inv8  = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); start8 = 1'b1; start20 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0; start20 = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checks++; if ({a8, b8, c8, d8, e8, f8, g8} !== 7'h00) begin errors++; $display("FAIL reset_vec: got %h want 00", {a8, b8, c8, d8, e8, f8, g8}); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy8); end
    checks++; if (done8 !== 1'b0 || pass8 !== 1'b0) begin errors++; $display("FAIL reset_done_pass: got %b%b want 00", done8, pass8); end
    checks++; if (vec_cnt8 !== 16'd0) begin errors++; $display("FAIL reset_vec_cnt: got %0d want 0", vec_cnt8); end
    checks++; if (err_cnt8 !== 16'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt8); end
    checks++; if (busy20 !== 1'b0 || vec_cnt20 !== 4'd0) begin errors++; $display("FAIL reset_dut20: busy %b vec_cnt %0d want 0 0", busy20, vec_cnt20); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_correct_run;
    int cyc;
    run8(32'h0, 1'b0, cyc);
    checks++; if (cyc !== 11) begin errors++; $display("FAIL run_busy_len: got %0d want 11", cyc); end
    for (int i = 0; i < C_N8; i++) begin
      checks++; if (seen8[i] !== exp_vec[i]) begin errors++; $display("FAIL run_vec%0d: got %h want %h", i, seen8[i], exp_vec[i]); end
    end
    checks++; if (done8 !== 1'b1 || pass8 !== 1'b1) begin errors++; $display("FAIL run_done_pass: got %b%b want 11", done8, pass8); end
    checks++; if (vec_cnt8 !== 16'd8) begin errors++; $display("FAIL run_vec_cnt: got %0d want 8", vec_cnt8); end
    checks++; if (err_cnt8 !== 16'd0) begin errors++; $display("FAIL run_err_cnt: got %0d want 0", err_cnt8); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (vec_cnt8 !== 16'd8 || done8 !== 1'b1) begin errors++; $display("FAIL done_hold: vec_cnt %0d done %b want 8 1", vec_cnt8, done8); end
  endtask

  task automatic test_inverted;
    int cyc;
    run8(32'h0, 1'b1, cyc);
    checks++; if (err_cnt8 !== 16'd8) begin errors++; $display("FAIL inv_err_cnt: got %0d want 8", err_cnt8); end
    checks++; if (done8 !== 1'b1 || pass8 !== 1'b0) begin errors++; $display("FAIL inv_done_pass: got %b%b want 10", done8, pass8); end
  endtask

  task automatic test_single_fault;
    int cyc;
    // vector 3's response is carried in cycle 5
    run8(32'h1 << 5, 1'b0, cyc);
    checks++; if (err_cnt8 !== 16'd1) begin errors++; $display("FAIL single_err_cnt: got %0d want 1", err_cnt8); end
    checks++; if (pass8 !== 1'b0) begin errors++; $display("FAIL single_pass: got %b want 0", pass8); end
  endtask

  task automatic test_random_faults;
    int cyc;
    logic [31:0] mask;
    int expect_err;
    for (int r = 0; r < 4; r++) begin
      mask = $urandom & 32'h0000_07FF;
      expect_err = 0;
      for (int cc = 2; cc <= C_N8 + 1; cc++) begin
        if (mask[cc]) expect_err++;
      end
      run8(mask, 1'b0, cyc);
      checks++; if (err_cnt8 !== 16'(expect_err)) begin errors++; $display("FAIL rand_err_cnt[%0d]: mask %h got %0d want %0d", r, mask, err_cnt8, expect_err); end
      checks++; if (pass8 !== (expect_err == 0)) begin errors++; $display("FAIL rand_pass[%0d]: got %b want %b", r, pass8, (expect_err == 0)); end
    end
  endtask

  task automatic test_abort;
    int k;
    int cyc;
    @(negedge clk); start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    k = 0;
    while (vec_cnt8 != 16'd4 && k < 32) begin @(posedge clk); #1; k++; end
    checks++; if (vec_cnt8 !== 16'd4 || busy8 !== 1'b1) begin errors++; $display("FAIL abort_reach: vec_cnt %0d busy %b want 4 1", vec_cnt8, busy8); end
    #2 rst = 1'b0;
    #1;
    checks++; if (busy8 !== 1'b0 || vec_cnt8 !== 16'd0 || err_cnt8 !== 16'd0) begin errors++; $display("FAIL abort_reset: busy %b vec %0d err %0d want 0 0 0", busy8, vec_cnt8, err_cnt8); end
    checks++; if ({a8, b8, c8, d8, e8, f8, g8} !== 7'h00 || done8 !== 1'b0) begin errors++; $display("FAIL abort_outputs: vec %h done %b want 00 0", {a8, b8, c8, d8, e8, f8, g8}, done8); end
    @(negedge clk); rst = 1'b1;
    run8(32'h0, 1'b0, cyc);
    checks++; if (seen8[0] !== 7'h61) begin errors++; $display("FAIL abort_first_vec: got %h want 61", seen8[0]); end
    for (int i = 1; i < C_N8; i++) begin
      checks++; if (seen8[i] !== exp_vec[i]) begin errors++; $display("FAIL abort_vec%0d: got %h want %h", i, seen8[i], exp_vec[i]); end
    end
    checks++; if (pass8 !== 1'b1 || err_cnt8 !== 16'd0) begin errors++; $display("FAIL abort_rerun: pass %b err %0d want 1 0", pass8, err_cnt8); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    inv20 = 1'b1;
    @(negedge clk); start20 = 1'b1;
    @(posedge clk); #1; start20 = 1'b0;
    cyc = 0;
    while (busy20 && cyc < 100) begin
      start20 = (cyc == 3) || (cyc == 21);
      @(posedge clk); #1;
      cyc++;
    end
    start20 = 1'b0;
    checks++; if (cyc !== 23) begin errors++; $display("FAIL b2b_busy_len: got %0d want 23", cyc); end
    checks++; if (err_cnt20 !== 4'hF) begin errors++; $display("FAIL b2b_saturate: got %h want f", err_cnt20); end
    checks++; if (done20 !== 1'b1 || pass20 !== 1'b0) begin errors++; $display("FAIL b2b_done_pass: got %b%b want 10", done20, pass20); end
    @(negedge clk); start20 = 1'b1;
    @(posedge clk); #1; start20 = 1'b0;
    checks++; if (vec_cnt20 !== 4'd0 || err_cnt20 !== 4'd0) begin errors++; $display("FAIL relaunch_clear: vec %0d err %0d want 0 0", vec_cnt20, err_cnt20); end
    checks++; if (busy20 !== 1'b1 || done20 !== 1'b0) begin errors++; $display("FAIL relaunch_state: busy %b done %b want 1 0", busy20, done20); end
    cyc = 0;
    while (busy20 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checks++; if (err_cnt20 !== 4'hF || done20 !== 1'b1) begin errors++; $display("FAIL relaunch_result: err %h done %b want f 1", err_cnt20, done20); end
    inv20 = 1'b0;
  endtask

  initial begin
    build_expect();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_correct_run();
    test_inverted();
    test_single_fault();
    test_random_faults();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
